// File: rtl/multicore_launch_ctrl_if.sv
// Launch/completion bus between the cluster start logic and the
// multicore launch controller.
//   master : drives start_process, core_mask and core_end and observes the
//            results (the top-level environment or testbench).
//   slave  : the controller. It drives core_begin, core_status, busy,
//            all_done, done_mask, cycle_count and timeout.
interface multicore_launch_ctrl_if #(
  parameter int NUM_CORES = 4,
  parameter int CNT_W     = 16
);
  logic                   start_process;
  logic [NUM_CORES-1:0]   core_mask;
  logic [NUM_CORES-1:0]   core_end;
  logic [NUM_CORES-1:0]   core_begin;
  logic [2*NUM_CORES-1:0] core_status;
  logic                   busy;
  logic                   all_done;
  logic [NUM_CORES-1:0]   done_mask;
  logic [CNT_W-1:0]       cycle_count;
  logic                   timeout;

  modport master (
    output start_process, core_mask, core_end,
    input  core_begin, core_status, busy, all_done, done_mask, cycle_count, timeout
  );

  modport slave (
    input  start_process, core_mask, core_end,
    output core_begin, core_status, busy, all_done, done_mask, cycle_count, timeout
  );
endinterface

// File: rtl/multicore_launch_ctrl.sv
// Launch and completion controller for an N-core cluster.
// A rising edge on start_process launches the cores selected by core_mask
// with a one-cycle core_begin pulse. Each launched core's end indication is
// then collected into done_mask, and all_done is raised once every launched
// core has finished. cycle_count counts RUN cycles (saturating).
//
// Ports:
//   clock    : system clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : multicore_launch_ctrl_if.slave
//              in : start_process, core_mask, core_end
//              out: core_begin, core_status (2 bits/core: 00 idle,
//                   01 running, 10 finished), busy, all_done, done_mask,
//                   cycle_count, timeout
//
// Optional feature: define WATCHDOG_EN to stop a launch after TIMEOUT RUN
// cycles and flag timeout. Without it, RUN waits indefinitely and timeout
// is always 0.
module multicore_launch_ctrl #(
  parameter int NUM_CORES = 4,
  parameter int CNT_W     = 16,
  parameter int TIMEOUT   = 1000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  multicore_launch_ctrl_if.slave   bus
);

`ifdef WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t                 state;
  logic                   start_q;
  logic [NUM_CORES-1:0]   active_mask;
  logic [NUM_CORES-1:0]   core_begin_r;
  logic [NUM_CORES-1:0]   done_mask_r;
  logic [CNT_W-1:0]       cycle_cnt_r;
  logic                   busy_r;
  logic                   all_done_r;
  logic                   timeout_r;

  logic                   launch_req;
  logic [NUM_CORES-1:0]   done_next;
  logic                   all_fin;
  logic                   wd_hit;
  logic [2*NUM_CORES-1:0] status_c;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign launch_req = bus.start_process & ~start_q & (|bus.core_mask);
  assign done_next  = done_mask_r | (bus.core_end & active_mask);
  assign all_fin    = (done_next == active_mask);
  assign wd_hit     = WD_EN & (cycle_cnt_r == WD_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      // start_process held high across reset must not look like a fresh
      // rising edge; a low level has to be seen before the next launch.
      start_q      <= 1'b1;
      active_mask  <= '0;
      core_begin_r <= '0;
      done_mask_r  <= '0;
      cycle_cnt_r  <= '0;
      busy_r       <= 1'b0;
      all_done_r   <= 1'b0;
      timeout_r    <= 1'b0;
    end else begin
      start_q <= bus.start_process;
      case (state)
        S_IDLE, S_DONE: begin
          if (launch_req) begin
            state        <= S_LAUNCH;
            active_mask  <= bus.core_mask;
            core_begin_r <= bus.core_mask;
            done_mask_r  <= '0;
            cycle_cnt_r  <= '0;
            busy_r       <= 1'b1;
            all_done_r   <= 1'b0;
            timeout_r    <= 1'b0;
          end
        end
        S_LAUNCH: begin
          // core_end is not looked at here: cores only just got begin.
          state        <= S_RUN;
          core_begin_r <= '0;
        end
        S_RUN: begin
          done_mask_r <= done_next;
          cycle_cnt_r <= sat_inc(cycle_cnt_r);
          // Completion wins over the watchdog on the same edge.
          if (all_fin) begin
            state      <= S_DONE;
            busy_r     <= 1'b0;
            all_done_r <= 1'b1;
          end else if (wd_hit) begin
            state      <= S_DONE;
            busy_r     <= 1'b0;
            all_done_r <= 1'b1;
            timeout_r  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status is derived from registered state only, so it holds through DONE.
  always_comb begin
    status_c = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (state == S_IDLE || !active_mask[i])
        status_c[2*i +: 2] = 2'b00;
      else if (done_mask_r[i])
        status_c[2*i +: 2] = 2'b10;
      else
        status_c[2*i +: 2] = 2'b01;
    end
  end

  assign bus.core_begin  = core_begin_r;
  assign bus.core_status = status_c;
  assign bus.busy        = busy_r;
  assign bus.all_done    = all_done_r;
  assign bus.done_mask   = done_mask_r;
  assign bus.cycle_count = cycle_cnt_r;
  assign bus.timeout     = timeout_r;

endmodule

// File: tb/tb_multicore_launch_ctrl.sv
module tb_multicore_launch_ctrl;
  localparam int NC = 4;
  localparam int CW = 16;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;
  int   n_fail = 0;

  always #5 clock = ~clock;

  multicore_launch_ctrl_if #(.NUM_CORES(NC), .CNT_W(CW)) bus ();

  multicore_launch_ctrl #(.NUM_CORES(NC), .CNT_W(CW), .TIMEOUT(8)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic relaunch(input logic [NC-1:0] m);
    bus.start_process = 1'b0;
    tick();
    bus.core_mask     = m;
    bus.start_process = 1'b1;
    tick();
  endtask

  initial begin
    bus.start_process = 1'b1;
    bus.core_mask     = 4'b1111;
    bus.core_end      = 4'b0000;

    // 1: reset with start held high
    repeat (3) tick();
    chk("rst_begin",  bus.core_begin,  0);
    chk("rst_busy",   bus.busy,        0);
    chk("rst_done",   bus.all_done,    0);
    chk("rst_status", bus.core_status, 0);
    chk("rst_count",  bus.cycle_count, 0);
    chk("rst_dmask",  bus.done_mask,   0);
    chk("rst_tmo",    bus.timeout,     0);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("held_no_begin", bus.core_begin, 0);
    chk("held_no_busy",  bus.busy,       0);

    // 2: full launch, cores end at RUN cycles 3,5,5,9
    relaunch(4'b1111);
    chk("l2_begin",  bus.core_begin,  4'b1111);
    chk("l2_busy",   bus.busy,        1);
    chk("l2_status", bus.core_status, 8'h55);
    tick();
    chk("l2_begin_off", bus.core_begin, 0);
    for (int r = 1; r <= 9; r++) begin
      bus.core_end = (r == 3) ? 4'b0001 : (r == 5) ? 4'b0110 : (r == 9) ? 4'b1000 : 4'b0000;
      tick();
      if (r == 3) chk("l2_dm3", bus.done_mask, 4'b0001);
      if (r == 5) chk("l2_dm5", bus.done_mask, 4'b0111);
      if (r == 8) chk("l2_notdone8", bus.all_done, 0);
    end
    bus.core_end = 4'b0000;
    chk("l2_dm9",    bus.done_mask,   4'b1111);
    chk("l2_done",   bus.all_done,    1);
    chk("l2_busy0",  bus.busy,        0);
    chk("l2_count",  bus.cycle_count, 9);
    chk("l2_status", bus.core_status, 8'hAA);
    repeat (2) tick();
    chk("l2_hold_cnt",  bus.cycle_count, 9);
    chk("l2_hold_stat", bus.core_status, 8'hAA);

    // 3: mask 0101, core_end 1111 from RUN cycle 2
    relaunch(4'b0101);
    chk("l3_begin",  bus.core_begin,  4'b0101);
    chk("l3_clrdone", bus.all_done,   0);
    chk("l3_dm0",    bus.done_mask,   0);
    chk("l3_status", bus.core_status, 8'h11);
    tick();
    tick();
    chk("l3_cnt1", bus.cycle_count, 1);
    chk("l3_dm1",  bus.done_mask,   0);
    bus.core_end = 4'b1111;
    tick();
    chk("l3_dm2",    bus.done_mask,   4'b0101);
    chk("l3_done",   bus.all_done,    1);
    chk("l3_status", bus.core_status, 8'h22);
    tick();
    chk("l3_dm_hold", bus.done_mask,  4'b0101);
    bus.core_end = 4'b0000;

    // 4: start edge mid-RUN ignored, then relaunch from DONE
    relaunch(4'b0011);
    chk("l4_begin", bus.core_begin, 4'b0011);
    tick();
    bus.start_process = 1'b0;
    tick();
    bus.start_process = 1'b1;
    tick();
    chk("l4_mid_begin", bus.core_begin,  0);
    chk("l4_mid_busy",  bus.busy,        1);
    chk("l4_mid_cnt",   bus.cycle_count, 2);
    bus.core_end = 4'b0011;
    tick();
    bus.core_end = 4'b0000;
    chk("l4_done", bus.all_done,    1);
    chk("l4_cnt",  bus.cycle_count, 3);
    relaunch(4'b0011);
    chk("l4_re_dm",  bus.done_mask,   0);
    chk("l4_re_cnt", bus.cycle_count, 0);
    chk("l4_re_beg", bus.core_begin,  4'b0011);

    // 5: asynchronous reset mid-RUN
    tick();
    repeat (4) tick();
    chk("l5_cnt4", bus.cycle_count, 4);
    reset_n = 1'b0;
    #1;
    chk("l5_busy",   bus.busy,        0);
    chk("l5_cnt",    bus.cycle_count, 0);
    chk("l5_status", bus.core_status, 0);
    chk("l5_begin",  bus.core_begin,  0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("l5_idle", bus.busy, 0);

    // start edge with empty mask stays idle
    relaunch(4'b0000);
    chk("m0_begin", bus.core_begin, 0);
    tick();
    chk("m0_busy", bus.busy, 0);

    // 6: watchdog / indefinite RUN, only core 0 ends
    relaunch(4'b0011);
    tick();
`ifdef WATCHDOG_EN
    for (int r = 1; r <= 8; r++) begin
      bus.core_end = (r == 2) ? 4'b0001 : 4'b0000;
      tick();
      if (r == 7) chk("wd_busy7", bus.busy, 1);
    end
    chk("wd_tmo",  bus.timeout,     1);
    chk("wd_done", bus.all_done,    1);
    chk("wd_dm",   bus.done_mask,   4'b0001);
    chk("wd_cnt",  bus.cycle_count, 8);
    relaunch(4'b0011);
    chk("wd_clr", bus.timeout, 0);
`else
    for (int r = 1; r <= 100; r++) begin
      bus.core_end = (r == 2) ? 4'b0001 : 4'b0000;
      tick();
    end
    chk("nwd_busy", bus.busy,        1);
    chk("nwd_tmo",  bus.timeout,     0);
    chk("nwd_done", bus.all_done,    0);
    chk("nwd_dm",   bus.done_mask,   4'b0001);
    chk("nwd_cnt",  bus.cycle_count, 100);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
